// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_pkg
//  Brief    : Shared types and constants for the shared repeated-addition
//             multiplier sequencer and its round-robin arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // Sequencer states; encoding is fixed so that state can be probed directly
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ADD    = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Default operand / product / datapath bus width
    localparam int DEFAULT_WIDTH = 16;

    // Width of a requester index; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_rr_sequencer_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb
//  Brief    : Combinational rotating-priority arbiter. Scans ptr, ptr+1, ...
//             (mod NREQ) and grants the first requester found.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb
    import mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    logic found;

    // First set request bit at or after the pointer, wrapping around
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int pos;
            pos = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = IDXW'(pos);
            end
        end
    end

    assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/mul_rr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mul_rr_sequencer
//  Brief    : Arbitrates NREQ requesters onto one repeated-addition multiplier
//             datapath, sequences ld_a/ld_b/clr_p/ld_p/dec_b, and returns a
//             registered product with a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_rr_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] opa,
    input  logic [NREQ*WIDTH-1:0] opb,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic [WIDTH-1:0]      dp_data,
    output logic                  ld_a,
    output logic                  ld_b,
    output logic                  clr_p,
    output logic                  ld_p,
    output logic                  dec_b,
    input  logic                  eqz,
    input  logic [WIDTH-1:0]      prod
);

    localparam int              IDXW       = idx_width(NREQ);
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NREQ - 1);
    localparam logic [IDXW-1:0] C_ONE      = IDXW'(1);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q,   idx_d;
    logic [IDXW-1:0]   ptr_q,   ptr_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic [WIDTH-1:0]  result_q, result_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IDXW-1:0]   arb_idx;
    logic              arb_any;

    logic [WIDTH-1:0]  opa_arr [NREQ];
    logic [WIDTH-1:0]  opb_arr [NREQ];

    // Unpack the flat operand buses into per-requester slices
    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign opa_arr[i] = opa[i*WIDTH +: WIDTH];
        assign opb_arr[i] = opb[i*WIDTH +: WIDTH];
    end

    rr_arb #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // State, grant, pointer and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            result_q <= result_d;
        end
    end

    // Next-state logic and datapath control decode
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        result_d = result_q;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        clr_p    = 1'b0;
        ld_p     = 1'b0;
        dec_b    = 1'b0;
        done     = 1'b0;
        dp_data  = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    idx_d   = arb_idx;
                    gnt_d   = arb_gnt;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                ld_a    = 1'b1;
                dp_data = opa_arr[idx_q];
                state_d = LOAD_B;
            end
            LOAD_B: begin
                ld_b    = 1'b1;
                clr_p   = 1'b1;
                dp_data = opb_arr[idx_q];
                state_d = ADD;
            end
            ADD: begin
                // One accumulate per remaining count; the zero test ends it
                ld_p  = ~eqz;
                dec_b = ~eqz;
                if (eqz) begin
                    result_d = prod;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                gnt_d   = '0;
                ptr_d   = (idx_q == C_LAST_IDX) ? '0 : (idx_q + C_ONE);
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign gnt    = gnt_q;
    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_rr_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mul_rr_sequencer
//  Brief    : Directed self-checking bench with a behavioural multiplier
//             datapath (A register, P accumulator, B down-counter).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_rr_sequencer;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] opa   = '0;
    logic [N*W-1:0] opb   = '0;
    logic [N-1:0]   gnt;
    logic           busy, done, ld_a, ld_b, clr_p, ld_p, dec_b, eqz;
    logic [W-1:0]   result, dp_data, prod;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural datapath shared by all requesters
    logic [W-1:0] a_q = '0;
    logic [W-1:0] b_q = '0;
    logic [W-1:0] p_q = '0;
    always @(posedge clk) begin
        if (ld_a)  a_q <= dp_data;
        if (ld_b)  b_q <= dp_data;
        else if (dec_b) b_q <= b_q - 1'b1;
        if (clr_p) p_q <= '0;
        else if (ld_p) p_q <= p_q + a_q;
    end
    assign eqz  = (b_q == '0);
    assign prod = p_q;

    mul_rr_sequencer #(.WIDTH(W), .NREQ(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .opa     (opa),
        .opb     (opb),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .dp_data (dp_data),
        .ld_a    (ld_a),
        .ld_b    (ld_b),
        .clr_p   (clr_p),
        .ld_p    (ld_p),
        .dec_b   (dec_b),
        .eqz     (eqz),
        .prod    (prod)
    );

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        opa[i*W +: W] = a;
        opb[i*W +: W] = b;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Steps negedges until done is seen or the budget runs out
    task automatic wait_done(input int max, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < max) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        req   = 4'b1111;
        set_ops(0, 16'd9, 16'd9);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_done_busy got=%b%b exp=00", done, busy); end
        checks++; if (result !== 16'd0) begin failures++; $display("FAIL reset_result got=%h exp=0000", result); end
        checks++; if ({ld_a, ld_b, clr_p, ld_p, dec_b} !== 5'b0 || dp_data !== 16'd0) begin
            failures++; $display("FAIL reset_ctrl got=%b/%h exp=00000/0000", {ld_a, ld_b, clr_p, ld_p, dec_b}, dp_data);
        end
        req   = '0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_req busy got=%b exp=0", busy); end
    endtask

    // 7 x 5 on requester 0; req is dropped mid-operation and must not abort
    task automatic test_basic();
        int  nldp = 0;
        int  lat  = 0;
        bit  bad  = 1'b0;
        logic [N-1:0] g_done = '0;
        set_ops(0, 16'd7, 16'd5);
        req = 4'b0001;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (ld_a !== 1'b1 || dp_data !== 16'd7 || gnt !== 4'b0001) begin
                    failures++; $display("FAIL basic_load_a ld_a=%b dp=%0d gnt=%b exp 1/7/0001", ld_a, dp_data, gnt);
                end
            end
            if (c == 2) begin
                checks++; if (ld_b !== 1'b1 || clr_p !== 1'b1 || dp_data !== 16'd5) begin
                    failures++; $display("FAIL basic_load_b ld_b=%b clr_p=%b dp=%0d exp 1/1/5", ld_b, clr_p, dp_data);
                end
            end
            if (c == 3) req = 4'b0000;
            if (ld_p === 1'b1) nldp++;
            if (ld_p !== dec_b) bad = 1'b1;
            if (done === 1'b1) begin
                lat    = c;
                g_done = gnt;
            end
        end
        checks++; if (nldp != 5 || bad) begin failures++; $display("FAIL basic_add_cycles got=%0d (pair_ok=%0b) exp=5", nldp, !bad); end
        // Sample index = sampling edge + 3 + opb, seen on the following negedge
        checks++; if (lat != 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", lat); end
        checks++; if (result !== 16'd35 || g_done !== 4'b0001) begin
            failures++; $display("FAIL basic_result got=%0d gnt=%b exp=35/0001", result, g_done);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL basic_release busy=%b gnt=%b exp 0/0000", busy, gnt); end
    endtask

    // opb = 0: no accumulate ever, result 0
    task automatic test_zero_b();
        int nact = 0;
        int lat  = 0;
        set_ops(1, 16'd123, 16'd0);
        req = 4'b0010;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (ld_p === 1'b1 || dec_b === 1'b1) nact++;
            if (done === 1'b1) begin
                lat = c;
                req = '0;
            end
        end
        checks++; if (nact != 0) begin failures++; $display("FAIL zero_b_active got=%0d exp=0", nact); end
        checks++; if (lat != 4) begin failures++; $display("FAIL zero_b_latency got=%0d exp=4", lat); end
        checks++; if (result !== 16'd0) begin failures++; $display("FAIL zero_b_result got=%0d exp=0", result); end
        @(negedge clk);
    endtask

    // Two requesters held high alternate 0, 2, 0
    task automatic test_alternate();
        logic [N-1:0] exp_g [3] = '{4'b0001, 4'b0100, 4'b0001};
        logic [W-1:0] exp_r [3] = '{16'd6, 16'd15, 16'd6};
        logic [N-1:0] got_g [3];
        logic [W-1:0] got_r [3];
        int  nd      = 0;
        bit  idle_ok = 1'b1;
        bit  idle_seen = 1'b1;
        bit  hot_bad = 1'b0;
        pulse_reset();
        set_ops(0, 16'd3, 16'd2);
        set_ops(2, 16'd5, 16'd3);
        req = 4'b0101;
        for (int c = 0; c < 60 && nd < 3; c++) begin
            @(negedge clk);
            if ($countones(gnt) > 1) hot_bad = 1'b1;
            if (done === 1'b1 && gnt === 4'b0000) hot_bad = 1'b1;
            if (busy === 1'b0) idle_seen = 1'b1;
            if (ld_a === 1'b1) begin
                if (!idle_seen) idle_ok = 1'b0;
                idle_seen = 1'b0;
            end
            if (done === 1'b1) begin
                got_g[nd] = gnt;
                got_r[nd] = result;
                nd++;
                if (nd == 3) req = '0;
            end
        end
        checks++; if (nd != 3) begin failures++; $display("FAIL alt_done_count got=%0d exp=3", nd); end
        for (int k = 0; k < 3 && k < nd; k++) begin
            checks++; if (got_g[k] !== exp_g[k] || got_r[k] !== exp_r[k]) begin
                failures++; $display("FAIL alt_op%0d gnt=%b res=%0d exp %b/%0d", k, got_g[k], got_r[k], exp_g[k], exp_r[k]);
            end
        end
        checks++; if (!idle_ok || hot_bad) begin failures++; $display("FAIL alt_gap_onehot idle_ok=%0b hot_bad=%0b exp 1/0", idle_ok, hot_bad); end
        @(negedge clk);
    endtask

    // All four requesting with opb = 1: fair rotation, six cycles per op
    task automatic test_all();
        logic [N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [W-1:0] exp_r [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd1};
        logic [N-1:0] got_g [5];
        logic [W-1:0] got_r [5];
        int nd = 0;
        pulse_reset();
        for (int i = 0; i < N; i++) set_ops(i, W'(i + 1), 16'd1);
        req = 4'b1111;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (nd < 5) begin
                    got_g[nd] = gnt;
                    got_r[nd] = result;
                end
                nd++;
                if (nd == 5) req = '0;
            end
        end
        checks++; if (nd != 5) begin failures++; $display("FAIL all_done_count got=%0d exp=5", nd); end
        for (int k = 0; k < 5 && k < nd; k++) begin
            checks++; if (got_g[k] !== exp_g[k] || got_r[k] !== exp_r[k]) begin
                failures++; $display("FAIL all_op%0d gnt=%b res=%0d exp %b/%0d", k, got_g[k], got_r[k], exp_g[k], exp_r[k]);
            end
        end
        @(negedge clk);
    endtask

    // Modulo-2^16 products and a zero multiplicand on requester 3
    task automatic test_wrap();
        logic [W-1:0] ta [4] = '{16'h0000, 16'hFFFF, 16'h0100, 16'd7};
        logic [W-1:0] tb [4] = '{16'd3,    16'd2,    16'h0100, 16'd9};
        logic [W-1:0] te [4] = '{16'h0000, 16'hFFFE, 16'h0000, 16'd63};
        for (int k = 0; k < 4; k++) begin
            int cyc;
            bit seen;
            set_ops(3, ta[k], tb[k]);
            req = 4'b1000;
            wait_done(int'(tb[k]) + 20, cyc, seen);
            req = '0;
            checks++; if (!seen || result !== te[k] || gnt !== 4'b1000 || cyc != int'(tb[k]) + 4) begin
                failures++; $display("FAIL wrap_%0d seen=%0b res=%h gnt=%b lat=%0d exp %h/1000/%0d", k, seen, result, gnt, cyc, te[k], int'(tb[k]) + 4);
            end
            @(negedge clk);
        end
    endtask

    // Reset in the middle of ADD, then a clean operation afterwards
    task automatic test_reset_mid();
        int cyc;
        bit seen;
        set_ops(2, 16'd5, 16'd9);
        req = 4'b0100;
        for (int c = 0; c < 10 && ld_p !== 1'b1; c++) @(negedge clk);
        checks++; if (ld_p !== 1'b1) begin failures++; $display("FAIL rmid_reach_add ld_p=%b exp=1", ld_p); end
        rst_n = 1'b0;
        req   = '0;
        #1;
        checks++; if (gnt !== 4'b0000 || done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rmid_state gnt=%b done=%b busy=%b exp 0000/0/0", gnt, done, busy);
        end
        checks++; if ({ld_a, ld_b, clr_p, ld_p, dec_b} !== 5'b0 || dp_data !== 16'd0 || result !== 16'd0) begin
            failures++; $display("FAIL rmid_ctrl ctrl=%b dp=%h res=%h exp 00000/0000/0000", {ld_a, ld_b, clr_p, ld_p, dec_b}, dp_data, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_ops(2, 16'd3, 16'd4);
        req = 4'b0100;
        wait_done(40, cyc, seen);
        req = '0;
        checks++; if (!seen || result !== 16'd12 || gnt !== 4'b0100 || cyc != 8) begin
            failures++; $display("FAIL rmid_after seen=%0b res=%0d gnt=%b lat=%0d exp 12/0100/8", seen, result, gnt, cyc);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_b();
        test_alternate();
        test_all();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
